// File: rtl/slt_pkg.sv
// Shared types and helpers for the sequential set-less-than engine.
// The state encoding and slice-count math live here so the top stays small.
package slt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough for any practical slice count; the top checks the fit.
    localparam int SLT_IDX_W = 8;

    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/slt_slice_cmp.sv
// Combinational unsigned lt/eq of one operand slice.
// invert_msb_i biases the top slice so a signed compare reduces to unsigned.
module slt_slice_cmp #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             invert_msb_i,
    output logic             lt_o,
    output logic             eq_o
);

    logic [SLICE-1:0] mask;
    logic [SLICE-1:0] a_b;
    logic [SLICE-1:0] b_b;

    always_comb begin
        mask            = '0;
        mask[SLICE-1]   = invert_msb_i;
        a_b             = a_i ^ mask;
        b_b             = b_i ^ mask;
        lt_o            = (a_b < b_b);
        eq_o            = (a_i == b_i);
    end

endmodule

// File: rtl/slt_seq.sv
// MSB-first multi-cycle set-less-than with start/done handshake.
// Define SLT_EARLY_EXIT_EN to stop on the first differing slice.
module slt_seq
    import slt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             set,
    output logic             eq
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam logic [SLT_IDX_W-1:0] LAST = SLT_IDX_W'(NSLICE - 1);

`ifdef SLT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    if ((WIDTH % SLICE) != 0) begin : g_bad_width
        $error("slt_seq: WIDTH must be a multiple of SLICE");
    end
    if (NSLICE > (1 << SLT_IDX_W)) begin : g_bad_idx
        $error("slt_seq: too many slices for index width");
    end

    state_t                 state_q, state_d;
    logic [SLT_IDX_W-1:0]   idx_q, idx_d;
    logic                   dec_q, dec_d;
    logic                   set_q, set_d;
    logic                   eq_q, eq_d;
    logic                   sgn_q, sgn_d;
    logic [WIDTH-1:0]       x_q, x_d;
    logic [WIDTH-1:0]       y_q, y_d;

    logic                   top_slice;
    logic                   s_lt;
    logic                   s_eq;
    logic                   hit;

    // Operands shift left each cycle so the live slice is always at the top.
    assign top_slice = sgn_q && (idx_q == LAST);

    slt_slice_cmp #(
        .SLICE (SLICE)
    ) u_cmp (
        .a_i          (x_q[WIDTH-1 -: SLICE]),
        .b_i          (y_q[WIDTH-1 -: SLICE]),
        .invert_msb_i (top_slice),
        .lt_o         (s_lt),
        .eq_o         (s_eq)
    );

    assign hit = !dec_q && !s_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            set_q   <= 1'b0;
            eq_q    <= 1'b0;
            sgn_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            set_q   <= set_d;
            eq_q    <= eq_d;
            sgn_q   <= sgn_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        set_d   = set_q;
        eq_d    = eq_q;
        sgn_d   = sgn_q;
        x_d     = x_q;
        y_d     = y_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    sgn_d   = is_signed;
                    idx_d   = LAST;
                    dec_d   = 1'b0;
                    set_d   = 1'b0;
                    eq_d    = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                x_d = x_q << SLICE;
                y_d = y_q << SLICE;
                if (hit) begin
                    dec_d = 1'b1;
                    set_d = s_lt;
                end
                if (hit && EARLY) begin
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                    eq_d    = !(dec_q || hit);
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign set  = set_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_slt_seq.sv
// Directed bench for slt_seq: vector table plus handshake/reset sequences.
// Expected latencies follow SLT_EARLY_EXIT_EN.
module tb_slt_seq;

`ifdef SLT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic        set;
    logic        eq;

    int n_pass;
    int n_total;

    slt_seq #(
        .WIDTH (32),
        .SLICE (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
        .y         (y),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .set       (set),
        .eq        (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        e_set;
        logic        e_eq;
        int          lat_early;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, output int lat,
                          output logic st, output logic e,
                          output logic bz_done, output logic bz_after,
                          output logic dn_after);
        @(negedge clk);
        x = a;
        y = b;
        is_signed = s;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x = ~a;
        y = ~b;
        is_signed = ~s;
        lat = -1;
        st = 1'bx;
        e = 1'bx;
        bz_done = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                lat = n;
                st = set;
                e = eq;
                bz_done = busy;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bz_after = busy;
        dn_after = done;
    endtask

    initial begin
        int          lat;
        logic        st, e, bzd, bza, dna;
        int          ndone;
        int          lat5;
        logic        set5, eq5, bza5;
        logic        saw_done;
        string       tag;

        n_pass = 0;
        n_total = 0;

        vecs[0]  = '{32'h0000_0001, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 9};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 2};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2};
        vecs[3]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 9};
        vecs[4]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 9};
        vecs[5]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 2};
        vecs[6]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 8};
        vecs[8]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 9};
        vecs[9]  = '{32'h0000_A000, 32'h0000_9FFF, 1'b0, 1'b0, 1'b0, 6};
        vecs[10] = '{32'h0000_A000, 32'h0000_9FFF, 1'b1, 1'b0, 1'b0, 6};
        vecs[11] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 2};

        rst_n = 1'b0;
        start = 1'b0;
        x = '0;
        y = '0;
        is_signed = 1'b0;
        #23;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_set",  {31'd0, set},  32'd0);
        chk("rst_eq",   {31'd0, eq},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, lat, st, e, bzd, bza, dna);
            tag = $sformatf("v%0d", i);
            chk({tag, "_set"}, {31'd0, st}, {31'd0, vecs[i].e_set});
            chk({tag, "_eq"},  {31'd0, e},  {31'd0, vecs[i].e_eq});
            chk({tag, "_lat"}, 32'(lat),
                EARLY ? 32'(vecs[i].lat_early) : 32'd9);
            chk({tag, "_busy_at_done"}, {31'd0, bzd}, 32'd1);
            chk({tag, "_busy_after"}, {31'd0, bza}, 32'd0);
            chk({tag, "_done_pulse"}, {31'd0, dna}, 32'd0);
        end

        // start held/pulsed while busy, inputs churning: one op only
        @(negedge clk);
        x = 32'd3;
        y = 32'd5;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        ndone = 0;
        lat5 = -1;
        set5 = 1'b0;
        eq5 = 1'b1;
        bza5 = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                lat5 = n;
                set5 = set;
                eq5 = eq;
            end
            if (n == lat5 + 1) bza5 = busy;
            if (busy) begin
                start = 1'b1;
                x = (n == 1) ? 32'd9 : $urandom;
                y = (n == 1) ? 32'd1 : $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("busy_ndone", 32'(ndone), 32'd1);
        chk("busy_lat", 32'(lat5), 32'd9);
        chk("busy_set", {31'd0, set5}, 32'd1);
        chk("busy_eq", {31'd0, eq5}, 32'd0);
        chk("busy_drop", {31'd0, bza5}, 32'd0);

        // asynchronous reset during the third CMP cycle
        @(negedge clk);
        x = 32'd1;
        y = 32'd2;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        chk("mid_set",  {31'd0, set},  32'd0);
        chk("mid_eq",   {31'd0, eq},   32'd0);
        saw_done = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("mid_no_done", {31'd0, saw_done}, 32'd0);

        run_op(32'd2, 32'd2, 1'b0, lat, st, e, bzd, bza, dna);
        chk("post_rst_eq", {31'd0, e}, 32'd1);
        chk("post_rst_set", {31'd0, st}, 32'd0);
        chk("post_rst_lat", 32'(lat), 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
